// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serdes_pkg
// Purpose  : Shared types and constants for the two-phase serializer:
//            FSM state encoding, line levels for the start/stop/idle bits
//            and the frame-length helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   WIDTH_DEFAULT = 8;
    localparam logic START_BIT     = 1'b1;
    localparam logic STOP_BIT      = 1'b0;
    localparam logic IDLE_LEVEL    = 1'b0;

    // Bits on the wire per word: start + WIDTH data + parity + stop.
    function automatic int frame_len(input int width);
        return width + 3;
    endfunction

endpackage : serdes_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for a single asynchronous level.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-low reset (both flops cleared to 0)
//            d   - asynchronous input level
//            q   - synchronized output level (two cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/serializer_2ph.sv
`default_nettype none
// ============================================================================
// Module   : serializer_2ph
// Purpose  : Accepts a parallel word over a two-phase req/ack handshake and
//            sends it as a serial frame: start(1), data MSB first, even
//            parity, stop(0). The line idles at 0.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-low reset
//            req  - two-phase request (toggle = new word offered)
//            data - parallel word, stable while req != ack
//            ack  - two-phase acknowledge, toggles once per frame
//            dout - registered serial output
//            busy - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module serializer_2ph
    import serdes_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] data,
    output logic             ack,
    output logic             dout,
    output logic             busy
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_req_s;
    logic              w_pending;
    logic [WIDTH-1:0]  r_shreg;
    logic              r_parity;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic              r_dout;
    logic              w_dout_nxt;
    logic              r_ack;
    logic              w_load;
    logic              w_shift;
    logic              w_ack_tgl;

    sync2 u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (w_req_s)
    );

    // Two-phase protocol: any difference between the synced request and our
    // acknowledge is an outstanding word. A double toggle cancels itself.
    assign w_pending = (w_req_s != r_ack);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pending) w_state_nxt = START;
            START:   w_state_nxt = DATA;
            DATA:    if (r_cnt == c_LAST) w_state_nxt = PARITY;
            PARITY:  w_state_nxt = STOP;
            STOP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: dout is registered, so each state decides the level the
    // line takes after the coming edge. The MSB goes out on the START->DATA
    // edge, so DATA itself only has WIDTH-1 bits left to shift before the
    // parity bit.
    always_comb begin
        w_dout_nxt = IDLE_LEVEL;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_ack_tgl  = 1'b0;
        w_cnt_nxt  = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_load     = 1'b1;
                    w_dout_nxt = START_BIT;
                end
            end
            START: begin
                w_dout_nxt = r_shreg[WIDTH-1];
                w_shift    = 1'b1;
            end
            DATA: begin
                if (r_cnt == c_LAST) begin
                    w_dout_nxt = r_parity;
                    w_cnt_nxt  = '0;
                end else begin
                    w_dout_nxt = r_shreg[WIDTH-1];
                    w_shift    = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end
            PARITY: begin
                w_dout_nxt = STOP_BIT;
                w_ack_tgl  = 1'b1;
            end
            STOP: begin
                w_dout_nxt = IDLE_LEVEL;
            end
            default: begin
                w_dout_nxt = IDLE_LEVEL;
            end
        endcase
    end

    // Datapath registers. Parity is captured at load time because the shift
    // register no longer holds the word by the time the parity bit is sent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_cnt    <= '0;
            r_dout   <= IDLE_LEVEL;
            r_ack    <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_load) begin
                r_shreg  <= data;
                r_parity <= ^data;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end
            if (w_ack_tgl) begin
                r_ack <= ~r_ack;
            end
        end
    end

    assign dout = r_dout;
    assign ack  = r_ack;
    assign busy = (r_state != IDLE);

endmodule : serializer_2ph
`default_nettype wire

// File: doc/serializer_2ph.md
SERIALIZER_2PH -- requirements
Module: serializer_2ph

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 1 bit: the two-phase request, where any toggle means a new word is offered.
REQ-005 The block SHALL have port data, input, WIDTH bits: the bundled parallel word, which the sender holds stable while req != ack.
REQ-006 The block SHALL have port ack, output, 1 bit: the two-phase acknowledge, which toggles once per completed frame.
REQ-007 The block SHALL have port dout, output, 1 bit: the registered serial stream feeding the downstream serdes din; the line idles at 0.
REQ-008 The block SHALL have port busy, output, 1 bit: asserted in every state except IDLE.

Function
REQ-009 req SHALL pass through a two-flop synchronizer (req_s) before use.
REQ-010 A request SHALL be pending whenever req_s != ack.
REQ-011 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP.
REQ-012 In IDLE with a request pending, the FSM SHALL, on the same edge: load data into the shift register; go to START; drive dout <= 1.
REQ-013 START SHALL go to DATA after one cycle.
REQ-014 DATA SHALL shift out WIDTH bits, MSB first, one per cycle, using a bit counter of ceil(log2(WIDTH)) bits that wraps to 0 on exit.
REQ-015 PARITY SHALL drive the even-parity bit, which is the XOR of the latched word.
REQ-016 STOP SHALL drive 0 for one cycle, toggle ack on the edge that enters STOP, then return to IDLE.
REQ-017 Timing: if req toggles before edge k, the start bit SHALL appear after edge k+2, data bit i (MSB = bit 0) after edge k+3+i, parity after edge k+3+WIDTH, and stop plus ack toggle after edge k+4+WIDTH.
REQ-018 The frame SHALL be WIDTH+3 bits long, followed by at least one IDLE cycle (dout=0) before the next start bit.
REQ-019 A req toggle while busy SHALL be held pending and served from IDLE after the current frame.
REQ-020 A double toggle of req within one frame is a protocol violation and SHALL produce no extra frame; no error flag is required.
REQ-021 Changes on data after the load edge SHALL NOT affect the frame in progress.
REQ-022 A req level of 1 at reset release SHALL be treated as a pending request, because ack resets to 0.

Reset
REQ-023 While rst=0 at a rising edge, the block SHALL set: state=IDLE, dout=0, ack=0, busy=0, bit counter=0, shift register=0, both synchronizer flops=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame on that edge without toggling ack; dout SHALL be 0 on the next cycle.

Structure
REQ-025 Package serdes_pkg SHALL hold: the state enum type, WIDTH_DEFAULT=8, START_BIT=1'b1, STOP_BIT=1'b0, IDLE_LEVEL=1'b0, and FRAME_LEN = WIDTH+3 as a function.
REQ-026 The synchronizer SHALL be a separate sub-module, sync2 (two flops, synchronous active-low reset to 0), instantiated once for req.

Verification
REQ-027 The bench SHALL cover reset behaviour: hold rst=0 for 5 cycles with req=0 -> dout=0, ack=0, busy=0 throughout.
REQ-028 The bench SHALL cover a single word: data=8'hA5 with req toggled 0->1 -> dout sequence 1,1,0,1,0,0,1,0,1,0,0 (start, data, parity 0, stop); ack becomes 1 after edge k+12.
REQ-029 The bench SHALL cover odd parity: data=8'h01 -> parity bit 1; data=8'hFF -> parity bit 0.
REQ-030 The bench SHALL cover back-to-back words: 8'h3C, then 8'hC3 toggled as soon as ack toggles -> two 11-bit frames separated by at least 1 idle 0, and ack toggles twice.
REQ-031 The bench SHALL cover a request during a busy frame: req toggles during the DATA state of 8'h0F, with data changed to 8'h55 -> the first frame still carries 8'h0F; 8'h55 follows once ack is returned.
REQ-032 The bench SHALL cover reset mid-frame: rst=0 during the 4th data bit -> dout=0 and busy=0 on the next cycle; ack unchanged at 0; a new req toggle afterwards yields a complete frame.
